// File: rtl/cga_tandy_regs.sv
// cga_tandy_regs
// ---------------------------------------------------------------------------
// CGA / Tandy-compatible video register block on an ISA-style I/O bus.
//
// Holds the CGA mode-control and colour-select registers, plus the Tandy
// indexed registers behind an index/data pair (border colour, mode select and
// a small palette). It also supplies the CRTC status byte on reads, maps pixel
// colour indices through the palette, and generates the text blink phase.
//
// Ports
//   clk, nRESET            sole clock; asynchronous active-low reset
//   bus_a[14:0], bus_aen   I/O address and DMA address-enable (high = no decode)
//   bus_ior_l, bus_iow_l   I/O read / write strobes, active low, async to clk
//   bus_d[7:0]             write data
//   bus_out[7:0], bus_dir  read data and "driving read data" flag
//   tandy_en               enables the indexed Tandy registers and palette
//   freeze                 holds the blink counter and blink phase
//   vsync_l, display_enable  CRTC status sources (sampled once in clk)
//   pix_idx[3:0]           pixel colour index in
//   pix_color[3:0]         palette-mapped colour out (one cycle latency)
//   control_reg, color_reg, border_col, modesel, video_enabled, blink
//                          register contents exported to the video pipeline
// ---------------------------------------------------------------------------
module cga_tandy_regs #(
  parameter logic [15:0] IO_BASE_ADDR       = 16'h3D0,
  parameter int          PAL_ENTRIES        = 16,
  parameter logic [23:0] BLINK_MAX          = 24'd3_579_545,
  parameter bit          NO_DISPLAY_DISABLE = 1'b0
) (
  input  logic        clk,
  input  logic        nRESET,
  input  logic [14:0] bus_a,
  input  logic        bus_aen,
  input  logic        bus_ior_l,
  input  logic        bus_iow_l,
  input  logic [7:0]  bus_d,
  output logic [7:0]  bus_out,
  output logic        bus_dir,
  input  logic        tandy_en,
  input  logic        freeze,
  input  logic        vsync_l,
  input  logic        display_enable,
  input  logic [3:0]  pix_idx,
  output logic [3:0]  pix_color,
  output logic [7:0]  control_reg,
  output logic [7:0]  color_reg,
  output logic [3:0]  border_col,
  output logic [4:0]  modesel,
  output logic        video_enabled,
  output logic        blink
);

  localparam logic [15:0] CTRL_ADDR  = IO_BASE_ADDR + 16'h0008;
  localparam logic [15:0] COLOR_ADDR = IO_BASE_ADDR + 16'h0009;
  localparam logic [15:0] STAT_ADDR  = IO_BASE_ADDR + 16'h000A;
  localparam logic [15:0] DATA_ADDR  = IO_BASE_ADDR + 16'h000E;
  localparam logic [4:0]  PAL_N      = 5'(PAL_ENTRIES);

  localparam logic [4:0]  IDX_BORDER  = 5'h02;
  localparam logic [4:0]  IDX_MODESEL = 5'h03;

  // ---------------------------------------------------------------------------
  // Address decode (combinational, blocked entirely during DMA cycles)
  // ---------------------------------------------------------------------------
  logic sel_ctrl;
  logic sel_color;
  logic sel_stat;
  logic sel_data;

  assign sel_ctrl  = !bus_aen && ({1'b0, bus_a} == CTRL_ADDR);
  assign sel_color = !bus_aen && ({1'b0, bus_a} == COLOR_ADDR);
  assign sel_stat  = !bus_aen && ({1'b0, bus_a} == STAT_ADDR);
  assign sel_data  = !bus_aen && ({1'b0, bus_a} == DATA_ADDR);

  // ---------------------------------------------------------------------------
  // Write strobe synchroniser and commit detection
  // ---------------------------------------------------------------------------
  logic       iow_meta_q, iow_meta_d;
  logic       iow_sync_q, iow_sync_d;
  logic       iow_prev_q, iow_prev_d;
  logic [1:0] settle_q,   settle_d;
  logic       armed_q,    armed_d;
  logic       wr_commit;

  // The synchroniser resets to "strobe idle", so a strobe already held low at
  // reset release would look like a fresh falling edge. Commits are only armed
  // once the synchroniser carries real post-reset samples (settle_q == 2) and
  // has seen the strobe idle; that forces a genuine deassert/assert cycle and
  // keeps the first commit well clear of the reset release.
  always_comb begin
    iow_meta_d = bus_iow_l;
    iow_sync_d = iow_meta_q;
    iow_prev_d = iow_sync_q;
    settle_d   = (settle_q == 2'd2) ? settle_q : settle_q + 2'd1;
    armed_d    = armed_q | ((settle_q == 2'd2) & iow_sync_q);
  end

  // Single-cycle pulse: synchronised strobe was high last cycle, low now.
  assign wr_commit = armed_q & iow_prev_q & ~iow_sync_q;

  always_ff @(posedge clk or negedge nRESET) begin
    if (!nRESET) begin
      iow_meta_q <= 1'b1;
      iow_sync_q <= 1'b1;
      iow_prev_q <= 1'b1;
      settle_q   <= 2'd0;
      armed_q    <= 1'b0;
    end else begin
      iow_meta_q <= iow_meta_d;
      iow_sync_q <= iow_sync_d;
      iow_prev_q <= iow_prev_d;
      settle_q   <= settle_d;
      armed_q    <= armed_d;
    end
  end

  // ---------------------------------------------------------------------------
  // CGA and Tandy registers
  // ---------------------------------------------------------------------------
  logic [7:0] ctrl_q,   ctrl_d;
  logic [7:0] color_q,  color_d;
  logic [4:0] idx_q,    idx_d;
  logic [3:0] border_q, border_d;
  logic [4:0] mode_q,   mode_d;
  logic       data_wr;

  assign data_wr = wr_commit && sel_data && tandy_en;

  always_comb begin
    ctrl_d   = ctrl_q;
    color_d  = color_q;
    idx_d    = idx_q;
    border_d = border_q;
    mode_d   = mode_q;
    if (wr_commit && sel_ctrl) begin
      ctrl_d = bus_d;
    end
    if (wr_commit && sel_color) begin
      color_d = bus_d;
    end
    if (wr_commit && sel_stat && tandy_en) begin
      idx_d = bus_d[4:0];
    end
    if (data_wr && (idx_q == IDX_BORDER)) begin
      border_d = bus_d[3:0];
    end
    if (data_wr && (idx_q == IDX_MODESEL)) begin
      mode_d = bus_d[4:0];
    end
  end

  always_ff @(posedge clk or negedge nRESET) begin
    if (!nRESET) begin
      ctrl_q   <= 8'h29;
      color_q  <= 8'h00;
      idx_q    <= 5'd0;
      border_q <= 4'd0;
      mode_q   <= 5'd0;
    end else begin
      ctrl_q   <= ctrl_d;
      color_q  <= color_d;
      idx_q    <= idx_d;
      border_q <= border_d;
      mode_q   <= mode_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Palette: entries 0..PAL_ENTRIES-1 live at indices 0x10+k. Slots beyond
  // PAL_ENTRIES are identity constants so the lookup mux stays 16 wide; the
  // range check in the pixel path keeps them from ever being selected.
  // ---------------------------------------------------------------------------
  logic [15:0][3:0] pal_rd;

  for (genvar gi = 0; gi < 16; gi++) begin : g_pal
    if (gi < PAL_ENTRIES) begin : g_impl
      logic [3:0] ent_q, ent_d;

      always_comb begin
        ent_d = ent_q;
        if (data_wr && (idx_q == 5'(16 + gi))) begin
          ent_d = bus_d[3:0];
        end
      end

      always_ff @(posedge clk or negedge nRESET) begin
        if (!nRESET) begin
          ent_q <= 4'(gi);
        end else begin
          ent_q <= ent_d;
        end
      end

      assign pal_rd[gi] = ent_q;
    end else begin : g_none
      assign pal_rd[gi] = 4'(gi);
    end
  end

  // ---------------------------------------------------------------------------
  // Pixel colour mapping. Reads the palette flops' current value, so a
  // same-cycle write to the looked-up entry shows up one cycle later.
  // ---------------------------------------------------------------------------
  logic [3:0] pix_q, pix_d;
  logic       pix_hit;

  assign pix_hit = tandy_en && ({1'b0, pix_idx} < PAL_N);

  always_comb begin
    pix_d = pix_idx;
    if (pix_hit) begin
      pix_d = pal_rd[pix_idx];
    end
  end

  always_ff @(posedge clk or negedge nRESET) begin
    if (!nRESET) begin
      pix_q <= 4'd0;
    end else begin
      pix_q <= pix_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Blink phase generator
  // ---------------------------------------------------------------------------
  logic [23:0] blink_cnt_q, blink_cnt_d;
  logic        blink_q,     blink_d;

  always_comb begin
    blink_cnt_d = blink_cnt_q;
    blink_d     = blink_q;
    if (!freeze) begin
      if (blink_cnt_q == BLINK_MAX) begin
        blink_cnt_d = 24'd0;
        blink_d     = ~blink_q;
      end else begin
        blink_cnt_d = blink_cnt_q + 24'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge nRESET) begin
    if (!nRESET) begin
      blink_cnt_q <= 24'd0;
      blink_q     <= 1'b0;
    end else begin
      blink_cnt_q <= blink_cnt_d;
      blink_q     <= blink_d;
    end
  end

  // ---------------------------------------------------------------------------
  // CRTC status sampling and read path
  // ---------------------------------------------------------------------------
  logic vs_q, vs_d;
  logic de_q, de_d;

  always_comb begin
    vs_d = vsync_l;
    de_d = display_enable;
  end

  always_ff @(posedge clk or negedge nRESET) begin
    if (!nRESET) begin
      vs_q <= 1'b1;
      de_q <= 1'b0;
    end else begin
      vs_q <= vs_d;
      de_q <= de_d;
    end
  end

  // Reads follow the raw strobe so data is valid within the ISA read window.
  always_comb begin
    bus_out = 8'h00;
    bus_dir = 1'b0;
    if (!bus_ior_l && sel_stat) begin
      bus_out = {4'b1111, vs_q, 2'b10, ~de_q};
      bus_dir = 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign control_reg   = ctrl_q;
  assign color_reg     = color_q;
  assign border_col    = border_q;
  assign modesel       = mode_q;
  assign pix_color     = pix_q;
  assign blink         = blink_q;
  assign video_enabled = NO_DISPLAY_DISABLE ? 1'b1 : ctrl_q[3];

endmodule

// File: tb/tb_cga_tandy_regs.sv
// Testbench for cga_tandy_regs: two instances (16-entry palette and 8-entry
// palette with display-disable override) share all inputs. Stimulus pushes
// expected values into a scoreboard queue; a negedge monitor pops and compares.
module tb_cga_tandy_regs;

  localparam logic [14:0] A_CTRL  = 15'h3D8;
  localparam logic [14:0] A_COLOR = 15'h3D9;
  localparam logic [14:0] A_STAT  = 15'h3DA;
  localparam logic [14:0] A_DATA  = 15'h3DE;
  localparam logic [14:0] A_OTHER = 15'h3DB;
  localparam int PAL0 = 16;
  localparam int PAL1 = 8;
  localparam int BM0  = 3;
  localparam int BM1  = 6;

  logic        clk;
  logic        nRESET;
  logic [14:0] bus_a;
  logic        bus_aen;
  logic        bus_ior_l;
  logic        bus_iow_l;
  logic [7:0]  bus_d;
  logic        tandy_en;
  logic        freeze;
  logic        vsync_l;
  logic        display_enable;
  logic [3:0]  pix_idx;

  logic [7:0] bus_out_o  [2];
  logic       bus_dir_o  [2];
  logic [3:0] pix_o      [2];
  logic [7:0] ctrl_o     [2];
  logic [7:0] color_o    [2];
  logic [3:0] border_o   [2];
  logic [4:0] mode_o     [2];
  logic       vid_o      [2];
  logic       blink_o    [2];

  cga_tandy_regs #(
    .IO_BASE_ADDR(16'h3D0), .PAL_ENTRIES(PAL0), .BLINK_MAX(24'(BM0)), .NO_DISPLAY_DISABLE(1'b0)
  ) u_dut0 (
    .clk(clk), .nRESET(nRESET), .bus_a(bus_a), .bus_aen(bus_aen),
    .bus_ior_l(bus_ior_l), .bus_iow_l(bus_iow_l), .bus_d(bus_d),
    .bus_out(bus_out_o[0]), .bus_dir(bus_dir_o[0]), .tandy_en(tandy_en),
    .freeze(freeze), .vsync_l(vsync_l), .display_enable(display_enable),
    .pix_idx(pix_idx), .pix_color(pix_o[0]), .control_reg(ctrl_o[0]),
    .color_reg(color_o[0]), .border_col(border_o[0]), .modesel(mode_o[0]),
    .video_enabled(vid_o[0]), .blink(blink_o[0])
  );

  cga_tandy_regs #(
    .IO_BASE_ADDR(16'h3D0), .PAL_ENTRIES(PAL1), .BLINK_MAX(24'(BM1)), .NO_DISPLAY_DISABLE(1'b1)
  ) u_dut1 (
    .clk(clk), .nRESET(nRESET), .bus_a(bus_a), .bus_aen(bus_aen),
    .bus_ior_l(bus_ior_l), .bus_iow_l(bus_iow_l), .bus_d(bus_d),
    .bus_out(bus_out_o[1]), .bus_dir(bus_dir_o[1]), .tandy_en(tandy_en),
    .freeze(freeze), .vsync_l(vsync_l), .display_enable(display_enable),
    .pix_idx(pix_idx), .pix_color(pix_o[1]), .control_reg(ctrl_o[1]),
    .color_reg(color_o[1]), .border_col(border_o[1]), .modesel(mode_o[1]),
    .video_enabled(vid_o[1]), .blink(blink_o[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- reference model ----------------
  logic [7:0] m_ctrl;
  logic [7:0] m_color;
  logic [4:0] m_idx;
  logic [3:0] m_border;
  logic [4:0] m_mode;
  logic [3:0] m_pal [2][16];
  int         blink_n = 0;   // clock edges with freeze low since last reset

  always @(posedge clk or negedge nRESET) begin
    if (!nRESET) blink_n <= 0;
    else if (!freeze) blink_n <= blink_n + 1;
  end

  function automatic int pal_n(input int inst);
    return (inst == 0) ? PAL0 : PAL1;
  endfunction

  function automatic void model_reset();
    m_ctrl = 8'h29; m_color = 8'h00; m_idx = 5'd0; m_border = 4'd0; m_mode = 5'd0;
    for (int i = 0; i < 2; i++)
      for (int k = 0; k < 16; k++) m_pal[i][k] = 4'(k);
  endfunction

  function automatic void model_write(input logic [14:0] a, input logic [7:0] d,
                                      input logic aen, input logic ten);
    int k;
    if (aen) return;
    if (a == A_CTRL) m_ctrl = d;
    else if (a == A_COLOR) m_color = d;
    else if (a == A_STAT && ten) m_idx = d[4:0];
    else if (a == A_DATA && ten) begin
      if (m_idx == 5'h02) m_border = d[3:0];
      else if (m_idx == 5'h03) m_mode = d[4:0];
      else if (m_idx >= 5'h10) begin
        k = int'(m_idx) - 16;
        for (int i = 0; i < 2; i++)
          if (k < pal_n(i)) m_pal[i][k] = d[3:0];
      end
    end
  endfunction

  function automatic logic [3:0] model_pix(input int inst, input logic [3:0] p, input logic ten);
    if (ten && int'(p) < pal_n(inst)) return m_pal[inst][p];
    return p;
  endfunction

  function automatic logic model_blink(input int inst);
    int period;
    period = ((inst == 0) ? BM0 : BM1) + 1;
    return ((blink_n / period) % 2) == 1;
  endfunction

  // ---------------- scoreboard ----------------
  typedef struct {
    int         inst;
    int         sel;
    logic [7:0] exp;
    int         due;
    string      name;
  } chk_t;

  chk_t sb_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  function automatic logic [7:0] get_act(input int inst, input int sel);
    case (sel)
      0: return ctrl_o[inst];
      1: return color_o[inst];
      2: return {4'd0, border_o[inst]};
      3: return {3'd0, mode_o[inst]};
      4: return {7'd0, vid_o[inst]};
      5: return {7'd0, blink_o[inst]};
      6: return {4'd0, pix_o[inst]};
      7: return bus_out_o[inst];
      default: return {7'd0, bus_dir_o[inst]};
    endcase
  endfunction

  task automatic push(input int inst, input int sel, input logic [7:0] exp,
                      input int due, input string name);
    chk_t c;
    c.inst = inst; c.sel = sel; c.exp = exp; c.due = due; c.name = name;
    sb_q.push_back(c);
  endtask

  always @(negedge clk) begin
    for (int i = 0; i < sb_q.size(); ) begin
      if (sb_q[i].due <= cyc) begin
        logic [7:0] act;
        act = get_act(sb_q[i].inst, sb_q[i].sel);
        n_tests++;
        if (act !== sb_q[i].exp) begin
          n_fail++;
          $display("FAIL %s inst%0d cycle %0d: got %h expected %h",
                   sb_q[i].name, sb_q[i].inst, cyc, act, sb_q[i].exp);
        end
        sb_q.delete(i);
      end else begin
        i++;
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_regs();
    for (int i = 0; i < 2; i++) begin
      push(i, 0, m_ctrl, cyc, "control_reg");
      push(i, 1, m_color, cyc, "color_reg");
      push(i, 2, {4'd0, m_border}, cyc, "border_col");
      push(i, 3, {3'd0, m_mode}, cyc, "modesel");
      push(i, 4, {7'd0, (i == 1) ? 1'b1 : m_ctrl[3]}, cyc, "video_enabled");
    end
  endtask

  task automatic check_pix(input logic [3:0] p);
    pix_idx = p;
    for (int i = 0; i < 2; i++)
      push(i, 6, {4'd0, model_pix(i, p, tandy_en)}, cyc + 1, "pix_color");
    step();
  endtask

  task automatic do_write(input logic [14:0] a, input logic [7:0] d,
                          input logic aen, input int hold);
    bus_a = a; bus_d = d; bus_aen = aen; bus_iow_l = 1'b0;
    repeat (hold) step();
    bus_iow_l = 1'b1;
    repeat (4) step();
    bus_aen = 1'b0;
    model_write(a, d, aen, tandy_en);
    $display("[TB] write a=%h d=%h aen=%0d tandy=%0d", a, d, aen, tandy_en);
  endtask

  task automatic do_read(input logic [14:0] a, input logic aen,
                         input logic vs, input logic de);
    logic hit;
    vsync_l = vs; display_enable = de;
    repeat (2) step();
    bus_a = a; bus_aen = aen; bus_ior_l = 1'b0;
    #1;
    hit = !aen && (a == A_STAT);
    for (int i = 0; i < 2; i++) begin
      push(i, 7, hit ? (8'hF4 | {4'd0, vs, 3'd0} | {7'd0, !de}) : 8'h00, cyc, "bus_out");
      push(i, 8, {7'd0, hit}, cyc, "bus_dir");
    end
    step();
    bus_ior_l = 1'b1; bus_aen = 1'b0;
    $display("[TB] read a=%h aen=%0d vs=%0d de=%0d", a, aen, vs, de);
  endtask

  task automatic check_reset_state();
    for (int i = 0; i < 2; i++) begin
      push(i, 5, 8'h00, cyc, "blink_reset");
      push(i, 6, 8'h00, cyc, "pix_reset");
    end
    check_regs();
  endtask

  task automatic blink_run(input int cycles, input int frz_pct);
    for (int n = 0; n < cycles; n++) begin
      step();
      for (int i = 0; i < 2; i++)
        push(i, 5, {7'd0, model_blink(i)}, cyc, "blink");
      freeze = ($urandom_range(0, 99) < frz_pct);
    end
    freeze = 1'b0;
    $display("[TB] blink run %0d cycles, freeze %0d%%", cycles, frz_pct);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // ---------------- main sequence ----------------
  initial begin
    logic [14:0] a;
    logic [7:0]  d;
    int          r;

    nRESET = 1'b0; bus_a = 15'd0; bus_aen = 1'b0; bus_ior_l = 1'b1; bus_iow_l = 1'b1;
    bus_d = 8'd0; tandy_en = 1'b0; freeze = 1'b0; vsync_l = 1'b1; display_enable = 1'b0;
    pix_idx = 4'd0;
    model_reset();
    #2;
    check_reset_state();
    repeat (2) step();
    nRESET = 1'b1;
    repeat (4) step();

    // Long strobe: one commit with the data present at commit time only.
    bus_a = A_CTRL; bus_d = 8'h1A; bus_aen = 1'b0; bus_iow_l = 1'b0;
    repeat (6) step();
    bus_d = 8'h55;
    repeat (4) step();
    bus_iow_l = 1'b1;
    repeat (4) step();
    model_write(A_CTRL, 8'h1A, 1'b0, 1'b0);
    $display("[TB] long write 3D8=1A");
    check_regs();
    step();

    // Tandy index/data with tandy enabled, then disabled.
    tandy_en = 1'b1;
    do_write(A_STAT, 8'h13, 1'b0, 3);
    do_write(A_DATA, 8'h0C, 1'b0, 3);
    check_regs();
    check_pix(4'd3);
    check_pix(4'd4);
    tandy_en = 1'b0;
    do_write(A_STAT, 8'h14, 1'b0, 3);
    do_write(A_DATA, 8'h05, 1'b0, 3);
    check_pix(4'd3);
    tandy_en = 1'b1;
    check_pix(4'd3);
    check_pix(4'd4);

    // Index beyond the 8-entry palette.
    do_write(A_STAT, 8'h1A, 1'b0, 4);
    do_write(A_DATA, 8'h05, 1'b0, 4);
    check_pix(4'd10);
    check_pix(4'd15);

    // Border / modesel and a DMA-blocked write.
    do_write(A_STAT, 8'h02, 1'b0, 3);
    do_write(A_DATA, 8'h0B, 1'b0, 3);
    do_write(A_STAT, 8'h03, 1'b0, 3);
    do_write(A_DATA, 8'h1F, 1'b0, 3);
    do_write(A_CTRL, 8'h00, 1'b1, 3);
    check_regs();

    // Status reads.
    do_read(A_STAT, 1'b0, 1'b0, 1'b1);
    do_read(A_COLOR, 1'b0, 1'b0, 1'b1);
    do_read(A_STAT, 1'b0, 1'b1, 1'b0);
    do_read(A_STAT, 1'b1, 1'b1, 1'b0);

    // Blink with and without freeze.
    blink_run(16, 0);
    freeze = 1'b1;
    blink_run(5, 100);
    blink_run(30, 30);

    // Reset mid-count, with a write strobe held across the release.
    nRESET = 1'b0;
    model_reset();
    bus_a = A_CTRL; bus_d = 8'h00; bus_iow_l = 1'b0;
    check_reset_state();
    repeat (2) step();
    nRESET = 1'b1;
    repeat (8) step();
    bus_iow_l = 1'b1;
    repeat (4) step();
    check_regs();
    blink_run(10, 0);
    do_write(A_CTRL, 8'h21, 1'b0, 3);
    check_regs();

    // Randomised traffic.
    for (int t = 0; t < 80; t++) begin
      tandy_en = ($urandom_range(0, 3) != 0);
      r = $urandom_range(0, 5);
      case (r)
        0: a = A_CTRL;
        1: a = A_COLOR;
        2: a = A_STAT;
        4: a = A_OTHER;
        default: a = A_DATA;
      endcase
      d = 8'($urandom);
      if (a == A_STAT) begin
        case ($urandom_range(0, 3))
          0: d[4:0] = 5'h02;
          1: d[4:0] = 5'h03;
          2: d[4:0] = 5'h10 | 5'($urandom_range(0, 15));
          default: d[4:0] = 5'($urandom);
        endcase
      end
      do_write(a, d, ($urandom_range(0, 7) == 0), $urandom_range(3, 6));
      check_regs();
      check_pix(4'($urandom_range(0, 15)));
      if (t % 4 == 0)
        do_read(($urandom_range(0, 2) == 0) ? A_OTHER : A_STAT, ($urandom_range(0, 5) == 0),
                1'($urandom), 1'($urandom));
    end
    blink_run(20, 25);

    repeat (3) step();
    if (sb_q.size() != 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", sb_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
